// File: rtl/hdmi_pattern_src.sv
// 640x480@60 style raster generator with selectable RGB test patterns.
// Counters advance only while running; every output is decoded from (h,v) and registered one cycle later.
`timescale 1ns/1ps
module hdmi_pattern_src #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_FP          = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BP          = 48,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FP          = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BP          = 33,
  parameter bit          VS_ACTIVE_LOW = 1'b1,
  parameter bit          HS_ACTIVE_LOW = 1'b1
) (
  input  logic        hdmi_clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pat_sel,
  input  logic [23:0] solid_rgb,
  output logic        hdmi_vs,
  output logic        hdmi_hs,
  output logic        hdmi_de,
  output logic [31:0] hdmi_data,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned CW      = 12;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [1:0]    pat_q;
  logic [23:0]   solid_q;

  logic          at_origin_c;
  logic          de_c;
  logic          hs_act_c;
  logic          vs_act_c;
  logic [1:0]    pat_c;
  logic [23:0]   solid_c;
  logic [2:0]    bar_idx_c;
  logic [23:0]   bar_rgb_c;
  logic [23:0]   rgb_c;

  // Pixel decode for the current counter position; pattern selection is taken live at (0,0).
  always_comb begin
    at_origin_c = (h_cnt == '0) && (v_cnt == '0);
    de_c        = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_act_c    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_act_c    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    pat_c       = at_origin_c ? pat_sel : pat_q;
    solid_c     = at_origin_c ? solid_rgb : solid_q;
    bar_idx_c   = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (h_cnt >= CW'(k * BAR_W)) bar_idx_c = 3'(k);
    end
    case (bar_idx_c)
      3'd0:    bar_rgb_c = 24'hFFFFFF;
      3'd1:    bar_rgb_c = 24'hFFFF00;
      3'd2:    bar_rgb_c = 24'h00FFFF;
      3'd3:    bar_rgb_c = 24'h00FF00;
      3'd4:    bar_rgb_c = 24'hFF00FF;
      3'd5:    bar_rgb_c = 24'hFF0000;
      3'd6:    bar_rgb_c = 24'h0000FF;
      default: bar_rgb_c = 24'h000000;
    endcase
    case (pat_c)
      2'd0:    rgb_c = bar_rgb_c;
      2'd1:    rgb_c = {3{h_cnt[9:2]}};
      2'd2:    rgb_c = (h_cnt[5] ^ v_cnt[5]) ? 24'hFFFFFF : 24'h000000;
      default: rgb_c = solid_c;
    endcase
  end

  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pat_q       <= '0;
      solid_q     <= '0;
      hdmi_de     <= 1'b0;
      hdmi_data   <= '0;
      hdmi_vs     <= VS_ACTIVE_LOW;
      hdmi_hs     <= HS_ACTIVE_LOW;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          h_cnt       <= '0;
          v_cnt       <= '0;
          hdmi_de     <= 1'b0;
          hdmi_data   <= '0;
          hdmi_vs     <= VS_ACTIVE_LOW;
          hdmi_hs     <= HS_ACTIVE_LOW;
          frame_start <= 1'b0;
          if (en) state <= RUN;
        end
        RUN: begin
          hdmi_de     <= de_c;
          hdmi_data   <= de_c ? {8'h00, rgb_c} : '0;
          hdmi_hs     <= hs_act_c ^ HS_ACTIVE_LOW;
          hdmi_vs     <= vs_act_c ^ VS_ACTIVE_LOW;
          frame_start <= at_origin_c;
          if (at_origin_c) begin
            pat_q   <= pat_sel;
            solid_q <= solid_rgb;
          end
          // Stopping is only honoured at the frame wrap so frames are never truncated by en.
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
              v_cnt     <= '0;
              frame_cnt <= frame_cnt + 8'd1;
              if (!en) state <= IDLE;
            end else begin
              v_cnt <= v_cnt + CW'(1);
            end
          end else begin
            h_cnt <= h_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_pattern_src.sv
// Directed bench: a reduced raster for pattern/timing checks and a tiny raster for frame_cnt wrap.
`timescale 1ns/1ps
module tb_hdmi_pattern_src;

  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 40, VFP = 2, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int WFRAME = (8 + 1 + 1 + 1) * (2 + 1 + 1 + 1);

  logic        clk = 1'b0;
  logic        rst, en, rst_w, en_w;
  logic [1:0]  pat_sel, pat_w;
  logic [23:0] solid_rgb, solid_w;
  logic        vs, hs, de, fs, vs_w, hs_w, de_w, fs_w;
  logic [31:0] data, data_w;
  logic [7:0]  fcnt, fcnt_w;

  always #5 clk = ~clk;

  hdmi_pattern_src #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .VS_ACTIVE_LOW(1'b1), .HS_ACTIVE_LOW(1'b1)
  ) dut (
    .hdmi_clk(clk), .rst(rst), .en(en), .pat_sel(pat_sel), .solid_rgb(solid_rgb),
    .hdmi_vs(vs), .hdmi_hs(hs), .hdmi_de(de), .hdmi_data(data),
    .frame_start(fs), .frame_cnt(fcnt)
  );

  hdmi_pattern_src #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .VS_ACTIVE_LOW(1'b1), .HS_ACTIVE_LOW(1'b1)
  ) dut_w (
    .hdmi_clk(clk), .rst(rst_w), .en(en_w), .pat_sel(pat_w), .solid_rgb(solid_w),
    .hdmi_vs(vs_w), .hdmi_hs(hs_w), .hdmi_de(de_w), .hdmi_data(data_w),
    .frame_start(fs_w), .frame_cnt(fcnt_w)
  );

  typedef struct {
    int          slot;
    int          x;
    int          y;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt [16];
  int          slot_pat [5] = '{0, 1, 2, 0, 3};
  logic [31:0] cap_data [5][FRAME];
  logic        cap_de [5][FRAME];
  logic        cap_hs [5][FRAME];
  logic        cap_vs [5][FRAME];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] bar_color(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [31:0] exp_data(input int pat, input int x, input int y);
    logic [7:0] g;
    if (x >= HA || y >= VA) return 32'h0;
    case (pat)
      0: return {8'h00, bar_color(x / (HA / 8))};
      1: begin g = 8'(x / 4); return {8'h00, g, g, g}; end
      2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 32'h00FFFFFF : 32'h0;
      default: return 32'h00123456;
    endcase
  endfunction

  task automatic wait_fs(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!fs && n < 2 * FRAME);
    check(tag, 32'(fs), 32'd1);
  endtask

  task automatic wait_fs_w(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!fs_w && n < 2 * WFRAME);
    check("fs_w_seen", 32'(fs_w), 32'd1);
  endtask

  // Current negedge is pixel (0,0); records one frame and checks the next frame_start.
  task automatic capture(input int s, input int chg_k);
    int nfs = 0;
    for (int k = 0; k < FRAME; k++) begin
      cap_data[s][k] = data;
      cap_de[s][k]   = de;
      cap_hs[s][k]   = hs;
      cap_vs[s][k]   = vs;
      if (k > 0 && fs) nfs++;
      if (k == chg_k) begin pat_sel = 2'd3; solid_rgb = 24'h123456; end
      @(negedge clk);
    end
    check($sformatf("fs_extra_s%0d", s), 32'(nfs), 32'd0);
    check($sformatf("fs_period_s%0d", s), 32'(fs), 32'd1);
  endtask

  initial begin
    int bad, first, cnt, lines, tot, nw, de_after, de_after_exp;
    logic [7:0] fc0, fc_exp;

    vt[0]  = '{0, 0, 0, 32'h00FFFFFF};   vt[1]  = '{0, 8, 0, 32'h00FFFF00};
    vt[2]  = '{0, 63, 0, 32'h00000000};  vt[3]  = '{0, 64, 0, 32'h00000000};
    vt[4]  = '{0, 16, 5, 32'h0000FFFF};  vt[5]  = '{0, 40, 39, 32'h00FF0000};
    vt[6]  = '{1, 4, 0, 32'h00010101};   vt[7]  = '{1, 63, 0, 32'h000F0F0F};
    vt[8]  = '{1, 0, 40, 32'h00000000};  vt[9]  = '{2, 32, 0, 32'h00FFFFFF};
    vt[10] = '{2, 32, 32, 32'h00000000}; vt[11] = '{2, 0, 32, 32'h00FFFFFF};
    vt[12] = '{2, 31, 31, 32'h00000000}; vt[13] = '{3, 24, 39, 32'h0000FF00};
    vt[14] = '{4, 0, 0, 32'h00123456};   vt[15] = '{4, 63, 39, 32'h00123456};

    rst = 1'b1; en = 1'b0; pat_sel = 2'd0; solid_rgb = 24'h0;
    rst_w = 1'b1; en_w = 1'b0; pat_w = 2'd0; solid_w = 24'h0;

    // Reset values, then a long idle with en low.
    repeat (2) @(negedge clk);
    check("rst_de", 32'(de), 32'd0);
    check("rst_data", data, 32'h0);
    check("rst_vs", 32'(vs), 32'd1);
    check("rst_hs", 32'(hs), 32'd1);
    check("rst_fs", 32'(fs), 32'd0);
    check("rst_fcnt", 32'(fcnt), 32'd0);
    rst = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (de !== 1'b0 || data !== 32'h0 || vs !== 1'b1 || hs !== 1'b1 || fs !== 1'b0 || fcnt !== 8'd0)
        bad++;
    end
    check("idle_hold", 32'(bad), 32'd0);

    // Start latency: en sampled at N, first pixel on the outputs at N+2.
    en = 1'b1;
    @(negedge clk);
    check("lat_n1_de", 32'(de), 32'd0);
    check("lat_n1_fs", 32'(fs), 32'd0);
    @(negedge clk);
    check("lat_n2_de", 32'(de), 32'd1);
    check("lat_n2_fs", 32'(fs), 32'd1);
    capture(0, -1);
    check("fcnt_after_first", 32'(fcnt), 32'd1);
    pat_sel = 2'd1;
    wait_fs("fs_to_p1");
    capture(1, -1);
    pat_sel = 2'd2;
    wait_fs("fs_to_p2");
    capture(2, -1);
    pat_sel = 2'd0;
    wait_fs("fs_to_p0");
    capture(3, 1000);
    capture(4, -1);

    for (int i = 0; i < 16; i++)
      check($sformatf("pix_s%0d_(%0d,%0d)", vt[i].slot, vt[i].x, vt[i].y),
            cap_data[vt[i].slot][vt[i].y * HT + vt[i].x], vt[i].exp);

    // Whole-frame comparison against the timing/pattern model.
    for (int s = 0; s < 5; s++) begin
      bad = 0; first = -1;
      for (int k = 0; k < FRAME; k++) begin
        int x, y;
        x = k % HT; y = k / HT;
        if (cap_data[s][k] !== exp_data(slot_pat[s], x, y) ||
            cap_de[s][k] !== (x < HA && y < VA) ||
            cap_hs[s][k] !== !(x >= HA + HFP && x < HA + HFP + HSY) ||
            cap_vs[s][k] !== !(y >= VA + VFP && y < VA + VFP + VSY)) begin
          bad++;
          if (first < 0) first = k;
        end
      end
      check($sformatf("model_s%0d_bad(first k=%0d)", s, first), 32'(bad), 32'd0);
    end

    // Sync placement and active-area shape of the bars frame.
    first = -1; cnt = 0;
    for (int k = 0; k < HT; k++)
      if (cap_hs[0][k] === 1'b0) begin if (first < 0) first = k; cnt++; end
    check("hs_start", 32'(first), 32'(HA + HFP));
    check("hs_len", 32'(cnt), 32'(HSY));
    first = -1; cnt = 0;
    for (int y = 0; y < VT; y++)
      if (cap_vs[0][y * HT] === 1'b0) begin if (first < 0) first = y; cnt++; end
    check("vs_first_line", 32'(first), 32'(VA + VFP));
    check("vs_lines", 32'(cnt), 32'(VSY));
    lines = 0; tot = 0;
    for (int y = 0; y < VT; y++) begin
      cnt = 0;
      for (int x = 0; x < HT; x++) if (cap_de[0][y * HT + x] === 1'b1) cnt++;
      if (cnt == HA) lines++;
      tot += cnt;
    end
    check("de_full_lines", 32'(lines), 32'(VA));
    check("de_total", 32'(tot), 32'(HA * VA));

    // en dropped mid-frame: the frame completes, counts, then the source idles.
    fc0 = fcnt;
    fc_exp = fc0 + 8'd1;
    de_after = 0; de_after_exp = 0;
    for (int k = 0; k <= FRAME; k++) begin
      if (k >= 500 && k < FRAME) begin
        if (de === 1'b1) de_after++;
        if ((k % HT) < HA && (k / HT) < VA) de_after_exp++;
      end
      if (k == FRAME - 2) check("stop_fcnt_before", 32'(fcnt), 32'(fc0));
      if (k == FRAME - 1) check("stop_fcnt_wrap", 32'(fcnt), 32'(fc_exp));
      if (k == FRAME) begin
        check("stop_de", 32'(de), 32'd0);
        check("stop_fs", 32'(fs), 32'd0);
        check("stop_data", data, 32'h0);
        check("stop_vs_hs", {30'd0, vs, hs}, 32'd3);
      end
      if (k == 500) en = 1'b0;
      if (k < FRAME) @(negedge clk);
    end
    check("stop_de_after_deassert", 32'(de_after), 32'(de_after_exp));
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (de !== 1'b0 || fs !== 1'b0 || fcnt !== fc_exp) bad++;
    end
    check("stop_idle_hold", 32'(bad), 32'd0);

    // Reset in the middle of an active line.
    en = 1'b1;
    wait_fs("fs_restart");
    repeat (30) @(negedge clk);
    check("pre_rst_de", 32'(de), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_de", 32'(de), 32'd0);
    check("midrst_data", data, 32'h0);
    check("midrst_vs_hs", {30'd0, vs, hs}, 32'd3);
    check("midrst_fs", 32'(fs), 32'd0);
    check("midrst_fcnt", 32'(fcnt), 32'd0);
    rst = 1'b0; en = 1'b0;

    // frame_cnt wrap on the tiny raster.
    @(negedge clk);
    rst_w = 1'b0;
    check("w_fcnt_rst", 32'(fcnt_w), 32'd0);
    en_w = 1'b1;
    bad = 0;
    for (int f = 0; f <= 256; f++) begin
      wait_fs_w(nw);
      if ((f == 0 && nw != 2) || (f > 0 && nw != WFRAME)) bad++;
      if (f == 255) check("w_fcnt_255", 32'(fcnt_w), 32'd255);
      if (f == 256) check("w_fcnt_wrap", 32'(fcnt_w), 32'd0);
    end
    check("w_fs_intervals", 32'(bad), 32'd0);
    en_w = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
